// File: rtl/audio_looper_pkg.sv
// -----------------------------------------------------------------------------
// audio_looper_pkg
// Shared definitions for the multi-channel looper:
//   - 2-bit state encoding (ST_IDLE / ST_RECORD / ST_PLAY)
//   - sat_add(): signed saturating add used by the overdub path
// -----------------------------------------------------------------------------
package audio_looper_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'b00;
    localparam state_t ST_RECORD = 2'b01;
    localparam state_t ST_PLAY   = 2'b10;

    // Adds two w-bit two's complement values (held in the low bits of a and b)
    // and clamps to [-(2**(w-1)), 2**(w-1)-1]. Result is in the low w bits.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic signed [64:0] sa;
        logic signed [64:0] sb;
        logic signed [64:0] sum;
        logic signed [64:0] lim;
        sa  = $signed({1'b0, a} << (65 - w)) >>> (65 - w);
        sb  = $signed({1'b0, b} << (65 - w)) >>> (65 - w);
        lim = 65'sd1 <<< (w - 1);
        sum = sa + sb;
        if (sum > lim - 65'sd1)
            sum = lim - 65'sd1;
        else if (sum < -lim)
            sum = -lim;
        return sum[63:0];
    endfunction

endpackage

// File: rtl/loop_ram.sv
// -----------------------------------------------------------------------------
// loop_ram
// Single-port loop memory, synchronous read, one access per cycle.
//   clk    : clock
//   en     : access enable
//   we     : 1 = write wdata to addr, 0 = read addr into rdata
//   addr   : word address
//   wdata  : write data
//   rdata  : read data, valid the cycle after a read; holds otherwise
// -----------------------------------------------------------------------------
module loop_ram #(
    parameter int WIDTH  = 48,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we)
                mem[addr] <= wdata;
            else
                rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/audio_looper_mc.sv
// -----------------------------------------------------------------------------
// audio_looper_mc
// Multi-channel record/playback looper between codec read and write data.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | pass input through, memory untouched
// RECORD| pass input through and append each frame to loop memory
// PLAY  | output stored loop (forward or reverse), input ignored
//
// Ports:
//   clk, reset_n   : clock, async active-low reset
//   sample_valid   : one-cycle strobe, in_data holds a new frame
//   in_data        : NCH*DATA_W frame, channel c at [c*DATA_W +: DATA_W]
//   rec_btn        : synchronised record/stop button (rising edge = press)
//   reverse        : play direction, sampled on every played sample
//   overdub        : (AUDIO_LOOPER_OVERDUB_EN only) mix input into loop in PLAY
//   out_data       : output frame
//   out_valid      : one-cycle strobe, one cycle after each sample_valid
//   state          : 00 IDLE, 01 RECORD, 10 PLAY
//   loop_len       : recorded length in samples, 0..2**ADDR_W
//
// Build option: define AUDIO_LOOPER_OVERDUB_EN to add the overdub port.
// With overdub the read-modify-write uses the cycle after each strobe, so
// sample_valid strobes must be at least two cycles apart.
// -----------------------------------------------------------------------------
module audio_looper_mc
    import audio_looper_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 16,
    parameter int NCH    = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sample_valid,
    input  logic [NCH*DATA_W-1:0] in_data,
    input  logic                  rec_btn,
    input  logic                  reverse,
`ifdef AUDIO_LOOPER_OVERDUB_EN
    input  logic                  overdub,
`endif
    output logic [NCH*DATA_W-1:0] out_data,
    output logic                  out_valid,
    output logic [1:0]            state,
    output logic [ADDR_W:0]       loop_len
);

    localparam int FW = NCH * DATA_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    logic              btn_q;
    logic              press;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] play_addr;     // last address played
    logic              play_started;  // 0 until the first read of a new loop
    logic [ADDR_W-1:0] len_m1;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   rec_count;
    logic              src_ram;       // out_data comes from memory read port
    logic [FW-1:0]     pass_q;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [FW-1:0]     ram_wdata;
    logic [FW-1:0]     ram_rdata;

    assign press     = rec_btn & ~btn_q;
    assign rec_count = {1'b0, wr_addr} + {{ADDR_W{1'b0}}, sample_valid};
    assign len_m1    = loop_len[ADDR_W-1:0] - ADDR_ONE;

    // Next address derives from the last played address and the current
    // reverse level, so a direction change steps back without a jump.
    always_comb begin
        rd_addr = '0;
        if (!play_started)
            rd_addr = reverse ? len_m1 : '0;
        else if (reverse)
            rd_addr = (play_addr == '0) ? len_m1 : play_addr - ADDR_ONE;
        else
            rd_addr = (play_addr == len_m1) ? '0 : play_addr + ADDR_ONE;
    end

`ifdef AUDIO_LOOPER_OVERDUB_EN
    logic              od_pend;
    logic [ADDR_W-1:0] od_addr_q;
    logic [FW-1:0]     od_in_q;
    logic [FW-1:0]     od_sum;

    always_comb begin
        logic [63:0] t;
        od_sum = '0;
        for (int c = 0; c < NCH; c++) begin
            t = sat_add(64'(ram_rdata[c*DATA_W +: DATA_W]),
                        64'(od_in_q[c*DATA_W +: DATA_W]), DATA_W);
            od_sum[c*DATA_W +: DATA_W] = t[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            od_pend   <= 1'b0;
            od_addr_q <= '0;
            od_in_q   <= '0;
        end else begin
            od_pend <= sample_valid && (state == ST_PLAY) && overdub;
            if (sample_valid) begin
                od_addr_q <= rd_addr;
                od_in_q   <= in_data;
            end
        end
    end
`endif

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = in_data;
`ifdef AUDIO_LOOPER_OVERDUB_EN
        if (od_pend) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = od_addr_q;
            ram_wdata = od_sum;
        end else
`endif
        if (sample_valid && state == ST_RECORD) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = wr_addr;
        end else if (sample_valid && state == ST_PLAY) begin
            ram_en   = 1'b1;
            ram_addr = rd_addr;
        end
    end

    loop_ram #(
        .WIDTH  (FW),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // The read port holds between reads, so memory can drive out_data directly.
    assign out_data = src_ram ? ram_rdata : pass_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            btn_q        <= 1'b0;
            wr_addr      <= '0;
            play_addr    <= '0;
            play_started <= 1'b0;
            loop_len     <= '0;
            out_valid    <= 1'b0;
            src_ram      <= 1'b0;
            pass_q       <= '0;
        end else begin
            btn_q     <= rec_btn;
            out_valid <= sample_valid;
            if (sample_valid) begin
                src_ram <= (state == ST_PLAY);
                if (state != ST_PLAY)
                    pass_q <= in_data;
            end

            case (state)
                ST_IDLE: begin
                    if (press) begin
                        state   <= ST_RECORD;
                        wr_addr <= '0;
                    end
                end
                ST_RECORD: begin
                    if (sample_valid)
                        wr_addr <= wr_addr + ADDR_ONE;
                    if ((sample_valid && wr_addr == ADDR_MAX) ||
                        (press && rec_count != '0)) begin
                        state        <= ST_PLAY;
                        loop_len     <= rec_count;
                        play_started <= 1'b0;
                    end else if (press) begin
                        state    <= ST_IDLE;
                        loop_len <= '0;
                    end
                end
                ST_PLAY: begin
                    if (sample_valid) begin
                        play_addr    <= rd_addr;
                        play_started <= 1'b1;
                    end
                    if (press)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_looper_mc.sv
module tb_audio_looper_mc;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 3;
    localparam int NCH    = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              sample_valid;
    logic [47:0]       in_data;
    logic              rec_btn;
    logic              reverse;
`ifdef AUDIO_LOOPER_OVERDUB_EN
    logic              overdub;
`endif
    logic [47:0]       out_data;
    logic              out_valid;
    logic [1:0]        state;
    logic [ADDR_W:0]   loop_len;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    audio_looper_mc #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NCH    (NCH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .in_data      (in_data),
        .rec_btn      (rec_btn),
        .reverse      (reverse),
`ifdef AUDIO_LOOPER_OVERDUB_EN
        .overdub      (overdub),
`endif
        .out_data     (out_data),
        .out_valid    (out_valid),
        .state        (state),
        .loop_len     (loop_len)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One strobe; out_valid/out_data checked one cycle later, then out_valid low.
    task automatic send48(input logic [47:0] din, input logic [47:0] exp, input string tag);
        @(negedge clk);
        in_data      = din;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        chk({tag, " valid"}, 64'(out_valid), 64'd1);
        chk({tag, " data"}, 64'(out_data), 64'(exp));
        @(negedge clk);
        sample_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, " valid_low"}, 64'(out_valid), 64'd0);
        chk({tag, " hold"}, 64'(out_data), 64'(exp));
    endtask

    task automatic send(input logic [23:0] v, input logic [23:0] e, input string tag);
        send48({v, v}, {e, e}, tag);
    endtask

    task automatic press_btn();
        @(negedge clk); rec_btn = 1'b1;
        @(negedge clk); @(negedge clk); rec_btn = 1'b0;
        @(negedge clk);
    endtask

    logic [23:0] fwd_exp [12];
    logic [23:0] rev_exp [4];

    initial begin
        fwd_exp = '{24'd10, 24'd11, 24'd12, 24'd13, 24'd14, 24'd10,
                    24'd11, 24'd12, 24'd13, 24'd14, 24'd10, 24'd11};
        rev_exp = '{24'd11, 24'd10, 24'd14, 24'd13};
        reset_n      = 1'b1;
        sample_valid = 1'b0;
        in_data      = '0;
        rec_btn      = 1'b0;
        reverse      = 1'b0;
`ifdef AUDIO_LOOPER_OVERDUB_EN
        overdub      = 1'b0;
`endif
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst state", 64'(state), 64'd0);
        chk("rst loop_len", 64'(loop_len), 64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_data", 64'(out_data), 64'd0);
        reset_n = 1'b1;

        // IDLE pass-through
        for (int i = 1; i <= 3; i++) send(24'(i), 24'(i), "idle_echo");
        chk("idle state", 64'(state), 64'd0);

        // Record 5 frames, play forward
        press_btn();
        chk("rec state", 64'(state), 64'd1);
        for (int i = 0; i < 5; i++) send(24'(10 + i), 24'(10 + i), "rec_echo");
        press_btn();
        chk("play state", 64'(state), 64'd2);
        chk("play loop_len", 64'(loop_len), 64'd5);
        for (int i = 0; i < 12; i++) send(24'h55, fwd_exp[i], "fwd");

        // Reverse after outputting 12
        send(24'h55, 24'd12, "fwd_last");
        reverse = 1'b1;
        for (int i = 0; i < 4; i++) send(24'h55, rev_exp[i], "rev");
        reverse = 1'b0;

        press_btn();
        chk("stop state", 64'(state), 64'd0);
        chk("stop loop_len held", 64'(loop_len), 64'd5);

        // Fill memory, auto-stop
        press_btn();
        chk("rec2 state", 64'(state), 64'd1);
        for (int i = 0; i < 8; i++) begin
            send(24'(20 + i), 24'(20 + i), "fill_echo");
            if (i == 6) chk("fill not yet full", 64'(state), 64'd1);
        end
        chk("auto play state", 64'(state), 64'd2);
        chk("auto loop_len", 64'(loop_len), 64'd8);
        send(24'h66, 24'd20, "auto_first");
        send(24'h66, 24'd21, "auto_second");

        // PLAY->IDLE, then empty record
        press_btn();
        chk("idle3 loop_len held", 64'(loop_len), 64'd8);
        press_btn();
        chk("empty rec state", 64'(state), 64'd1);
        press_btn();
        chk("empty rec state idle", 64'(state), 64'd0);
        chk("empty rec loop_len", 64'(loop_len), 64'd0);

        // Short loop, reverse start, then reset mid-PLAY
        press_btn();
        for (int i = 0; i < 3; i++) send(24'(40 + i), 24'(40 + i), "rec3_echo");
        reverse = 1'b1;
        press_btn();
        chk("rec3 loop_len", 64'(loop_len), 64'd3);
        send(24'h77, 24'd42, "rev_start");
        send(24'h77, 24'd41, "rev_next");
        reverse = 1'b0;
        @(negedge clk);
        in_data = '0; sample_valid = 1'b1;
        @(posedge clk); #1;
        chk("pre-reset valid", 64'(out_valid), 64'd1);
        chk("pre-reset data", 64'(out_data), {16'd0, 24'd42, 24'd42});
        reset_n = 1'b0; #1;
        sample_valid = 1'b0;
        chk("rst play state", 64'(state), 64'd0);
        chk("rst play loop_len", 64'(loop_len), 64'd0);
        chk("rst play valid", 64'(out_valid), 64'd0);
        chk("rst play data", 64'(out_data), 64'd0);
        @(negedge clk); reset_n = 1'b1;

        // Reset mid-RECORD
        press_btn();
        send(24'd50, 24'd50, "rec4_echo");
        @(negedge clk);
        in_data = {24'd51, 24'd51}; sample_valid = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b0; #1;
        sample_valid = 1'b0;
        chk("rst rec state", 64'(state), 64'd0);
        chk("rst rec valid", 64'(out_valid), 64'd0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        chk("post-reset state", 64'(state), 64'd0);

`ifdef AUDIO_LOOPER_OVERDUB_EN
        press_btn();
        send48({24'h800010, 24'h7FFFF0}, {24'h800010, 24'h7FFFF0}, "od_rec0");
        send48({24'h000005, 24'h000003}, {24'h000005, 24'h000003}, "od_rec1");
        press_btn();
        chk("od loop_len", 64'(loop_len), 64'd2);
        overdub = 1'b1;
        send48({24'hFFFF00, 24'h000100}, {24'h800010, 24'h7FFFF0}, "od_pass0");
        send48({24'h000010, 24'h000020}, {24'h000005, 24'h000003}, "od_pass1");
        overdub = 1'b0;
        send48('0, {24'h800000, 24'h7FFFFF}, "od_sat");
        send48('0, {24'h000015, 24'h000023}, "od_sum");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
